// File: rtl/sigma_arb_pkg.sv
// Shared widths, request bundle type and a width helper for the sigma memory arbiter.
package sigma_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } arb_req_t;

    // Index width that stays legal (>= 1 bit) when only one entry exists.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sigma_arb_tagfifo.sv
// Synchronous FIFO of master-ID tags recording the issue order of outstanding reads.
module sigma_arb_tagfifo
    import sigma_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int ID_W  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [ID_W-1:0] din_i,
    output logic [ID_W-1:0] dout_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = id_width(DEPTH);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sigma_mem_arbiter.sv
// Round-robin arbiter sharing one slave port between UDM and CPU masters, with in-order read return.
// Define SIGMA_ARB_DBG_PRIO_EN to give master 0 (UDM) strict priority over the round-robin.
module sigma_mem_arbiter
    import sigma_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int RD_DEPTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic [N_MASTERS-1:0]        m_req_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [N_MASTERS*BE_W-1:0]   m_be_i,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [N_MASTERS-1:0]        m_ack_o,
    output logic [N_MASTERS-1:0]        m_resp_o,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic                        s_req_o,
    output logic                        s_we_o,
    output logic [ADDR_W-1:0]           s_addr_o,
    output logic [BE_W-1:0]             s_be_o,
    output logic [DATA_W-1:0]           s_wdata_o,
    input  logic                        s_ack_i,
    input  logic                        s_resp_i,
    input  logic [DATA_W-1:0]           s_rdata_i,
    output logic                        err_o
);

    localparam int ID_W  = id_width(N_MASTERS);
    localparam int CNT_W = $clog2(RD_DEPTH + 1);

    arb_req_t             req_vec [N_MASTERS];
    arb_req_t             sel_req;
    logic [N_MASTERS-1:0] elig;
    logic [N_MASTERS-1:0] elig_rr;
    logic [ID_W-1:0]      pick, grant, head_id;
    logic                 pick_found;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      lock_id_q, lock_id_d;
    logic                 lock_vld_q, lock_vld_d;
    logic                 err_q, err_d;
    logic                 rd_stall, xfer, push, pop;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    function automatic logic [ID_W-1:0] rr_pick(
        input  logic [N_MASTERS-1:0] cand,
        input  logic [ID_W-1:0]      start,
        output logic                 found
    );
        int idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = int'(start) + i;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!found && cand[idx]) begin
                found   = 1'b1;
                rr_pick = ID_W'(idx);
            end
        end
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] g);
        return (g == ID_W'(N_MASTERS - 1)) ? '0 : g + ID_W'(1);
    endfunction

    // The stall looks at the registered count only, so a same-cycle pop does not release it.
    assign rd_stall = (fifo_count == CNT_W'(RD_DEPTH));

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            req_vec[k].we    = m_we_i[k];
            req_vec[k].addr  = m_addr_i[ADDR_W*k +: ADDR_W];
            req_vec[k].be    = m_be_i[BE_W*k +: BE_W];
            req_vec[k].wdata = m_wdata_i[DATA_W*k +: DATA_W];
            elig[k]          = m_req_i[k] & (m_we_i[k] | ~rd_stall);
        end
    end

    always_comb begin
        elig_rr    = elig;
        pick       = '0;
        pick_found = 1'b0;
`ifdef SIGMA_ARB_DBG_PRIO_EN
        elig_rr[0] = 1'b0;
        if (elig[0]) begin
            pick_found = 1'b1;
        end else begin
            pick = rr_pick(elig_rr, rr_ptr_q, pick_found);
        end
`else
        pick = rr_pick(elig_rr, rr_ptr_q, pick_found);
`endif
    end

    assign grant     = lock_vld_q ? lock_id_q : pick;
    assign s_req_o   = lock_vld_q ? m_req_i[lock_id_q] : pick_found;
    assign sel_req   = req_vec[grant];
    assign s_we_o    = sel_req.we;
    assign s_addr_o  = sel_req.addr;
    assign s_be_o    = sel_req.be;
    assign s_wdata_o = sel_req.wdata;

    assign xfer = s_req_o & s_ack_i;
    assign push = xfer & ~sel_req.we & ~fifo_full;
    assign pop  = s_resp_i & ~fifo_empty;

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            m_ack_o[k]  = xfer & (grant == ID_W'(k));
            m_resp_o[k] = pop & (head_id == ID_W'(k));
        end
    end

    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_q;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        err_d      = err_q | (s_resp_i & fifo_empty);
        if (xfer) begin
            lock_vld_d = 1'b0;
`ifdef SIGMA_ARB_DBG_PRIO_EN
            if (grant != '0) rr_ptr_d = next_id(grant);
`else
            rr_ptr_d = next_id(grant);
`endif
        end else if (s_req_o) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            err_q      <= err_d;
        end
    end

    sigma_arb_tagfifo #(
        .DEPTH (RD_DEPTH),
        .ID_W  (ID_W)
    ) u_tagfifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (grant),
        .dout_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Directed plus randomized bench for sigma_mem_arbiter against a queue-based reference model.
module tb_sigma_mem_arbiter;

    localparam int N        = 3;
    localparam int RD_DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic [N-1:0]  m_req, m_we, m_ack, m_resp;
    logic [N*32-1:0] m_addr, m_wdata;
    logic [N*4-1:0]  m_be;
    logic [31:0]   m_rdata;
    logic          s_req, s_we, s_ack, s_resp, err;
    logic [31:0]   s_addr, s_wdata, s_rdata;
    logic [3:0]    s_be;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  tq[$];
    int  rr;
    bit  lock_v;
    int  lock_id;
    bit  merr;

    logic [N-1:0] obs_ack, obs_resp;
    logic         obs_sreq;
    logic [31:0]  obs_saddr;

    sigma_mem_arbiter #(.N_MASTERS(N), .RD_DEPTH(RD_DEPTH)) dut (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_be_i    (m_be),
        .m_wdata_i (m_wdata),
        .m_ack_o   (m_ack),
        .m_resp_o  (m_resp),
        .m_rdata_o (m_rdata),
        .s_req_o   (s_req),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_be_o    (s_be),
        .s_wdata_o (s_wdata),
        .s_ack_i   (s_ack),
        .s_resp_i  (s_resp),
        .s_rdata_i (s_rdata),
        .err_o     (err)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        m_req[k]          = req;
        m_we[k]           = we;
        m_addr[32*k +: 32]  = a;
        m_wdata[32*k +: 32] = d;
        m_be[4*k +: 4]      = 4'hF;
    endtask

    task automatic model_reset();
        tq.delete();
        rr      = 0;
        lock_v  = 1'b0;
        lock_id = 0;
        merr    = 1'b0;
    endtask

    // One clock: compare DUT against the model at the falling edge, then advance the model.
    task automatic cycle();
        bit full, found;
        int g;
        bit elig [N];
        logic [N-1:0] eack, eresp;
        @(negedge clk_i);
        full = (tq.size() == RD_DEPTH);
        for (int k = 0; k < N; k++) elig[k] = m_req[k] && (m_we[k] || !full);
        found = 1'b0;
        g     = 0;
        if (lock_v) begin
            g     = lock_id;
            found = m_req[g];
        end else begin
`ifdef SIGMA_ARB_DBG_PRIO_EN
            if (elig[0]) begin
                g     = 0;
                found = 1'b1;
            end
`endif
            for (int i = 0; i < N; i++) begin
                int k;
                k = (rr + i) % N;
                if (!found && elig[k]) begin
                    g     = k;
                    found = 1'b1;
                end
            end
        end
        chk("s_req", 32'(s_req), 32'(found));
        if (found) begin
            chk("s_addr", s_addr, m_addr[32*g +: 32]);
            chk("s_we", 32'(s_we), 32'(m_we[g]));
            chk("s_be", 32'(s_be), 32'(m_be[4*g +: 4]));
            chk("s_wdata", s_wdata, m_wdata[32*g +: 32]);
        end
        eack = '0;
        if (found && s_ack) eack[g] = 1'b1;
        chk("m_ack", 32'(m_ack), 32'(eack));
        eresp = '0;
        if (s_resp && tq.size() > 0) eresp[tq[0]] = 1'b1;
        chk("m_resp", 32'(m_resp), 32'(eresp));
        if (s_resp) chk("m_rdata", m_rdata, s_rdata);
        chk("err", 32'(err), 32'(merr));
        obs_ack   = m_ack;
        obs_resp  = m_resp;
        obs_sreq  = s_req;
        obs_saddr = s_addr;
        if (s_resp) begin
            if (tq.size() > 0) void'(tq.pop_front());
            else merr = 1'b1;
        end
        if (found && s_ack) begin
            if (!m_we[g]) tq.push_back(g);
            lock_v = 1'b0;
`ifdef SIGMA_ARB_DBG_PRIO_EN
            if (g != 0) rr = (g + 1) % N;
`else
            rr = (g + 1) % N;
`endif
        end else if (found) begin
            lock_v  = 1'b1;
            lock_id = g;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int gseq [6];
        bit drained;
        arst_i  = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        model_reset();
        #12;
        arst_i = 1'b0;
        #1;
        chk("reset_sreq", 32'(s_req), 32'd0);
        chk("reset_ack", 32'(m_ack), 32'd0);
        chk("reset_resp", 32'(m_resp), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(posedge clk_i);
        #1;

        // Round-robin reads, then responses routed in order
        for (int k = 0; k < N; k++) set_m(k, 1'b1, 1'b0, 32'h1000 + 32'(k*4), 32'h0);
        s_ack = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < N; k++) begin
                cycle();
                chk("rr_grant", 32'(obs_ack), 32'(1 << k));
            end
            m_req = '0;
            for (int k = 0; k < N; k++) begin
                s_resp  = 1'b1;
                s_rdata = 32'hA0 + 32'(k);
                cycle();
                chk("rr_resp_route", 32'(obs_resp), 32'(1 << k));
            end
            s_resp = 1'b0;
            m_req  = 3'b111;
        end
        m_req = '0;

        // Lock: master 1 write stalled for 5 cycles while master 0 waits
        s_ack = 1'b0;
        set_m(1, 1'b1, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("lock_addr", obs_saddr, 32'h8000_0000);
            chk("lock_noack", 32'(obs_ack), 32'd0);
            set_m(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        end
        s_ack = 1'b1;
        cycle();
        chk("lock_release_m1", 32'(obs_ack), 32'b010);
        m_req[1] = 1'b0;
        cycle();
        chk("lock_next_m0", 32'(obs_ack), 32'b001);
        m_req[0] = 1'b0;
        s_resp  = 1'b1;
        s_rdata = 32'h1234_5678;
        cycle();
        s_resp = 1'b0;

        // FIFO full: four reads from master 2 with no responses
        set_m(2, 1'b1, 1'b0, 32'h2000, 32'h0);
        for (int c = 0; c < RD_DEPTH; c++) cycle();
        chk("full_count", 32'(dut.fifo_count), 32'(RD_DEPTH));
        set_m(1, 1'b1, 1'b1, 32'h3000, 32'h5555_AAAA);
        cycle();
        chk("full_write_acked", 32'(obs_ack), 32'b010);
        m_req[1] = 1'b0;
        cycle();
        chk("full_read_blocked", 32'(obs_sreq), 32'd0);
        s_resp  = 1'b1;
        s_rdata = 32'h55;
        cycle();
        chk("full_mask_on_pop", 32'(obs_sreq), 32'd0);
        chk("full_pop_route", 32'(obs_resp), 32'b100);
        s_resp = 1'b0;
        cycle();
        chk("full_read_resumes", 32'(obs_ack), 32'b100);
        m_req[2] = 1'b0;
        s_resp   = 1'b1;
        for (int c = 0; c < RD_DEPTH; c++) begin
            s_rdata = 32'hB0 + 32'(c);
            cycle();
        end
        s_resp = 1'b0;

        // Masters 0 and 2 compete continuously
        set_m(0, 1'b1, 1'b0, 32'h4000, 32'h0);
        set_m(2, 1'b1, 1'b0, 32'h4800, 32'h0);
        for (int c = 0; c < 6; c++) begin
            cycle();
            gseq[c] = (obs_ack == 3'b001) ? 0 : (obs_ack == 3'b100) ? 2 : -1;
            s_resp  = 1'b1;
            s_rdata = 32'hC0 + 32'(c);
        end
        m_req = '0;
        cycle();
        s_resp = 1'b0;
        for (int c = 0; c < 6; c++) begin
`ifdef SIGMA_ARB_DBG_PRIO_EN
            chk("prio_grant", 32'(gseq[c]), 32'd0);
`else
            chk("alt_grant", 32'(gseq[c]), (c % 2 == 0) ? 32'd0 : 32'd2);
`endif
        end

        // Randomized traffic checked every cycle by the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(m_req[k] && !obs_ack[k])) begin
                    set_m(k, ($urandom_range(0, 99) < 60), $urandom_range(0, 1) == 1,
                          $urandom, $urandom);
                    m_be[4*k +: 4] = 4'($urandom);
                end
            end
            s_ack   = ($urandom_range(0, 3) != 0);
            s_resp  = (tq.size() > 0) && ($urandom_range(0, 2) != 0);
            s_rdata = $urandom;
            cycle();
        end
        for (int k = 0; k < N; k++) if (obs_ack[k]) m_req[k] = 1'b0;

        // Drain outstanding requests and reads
        drained = 1'b0;
        s_ack   = 1'b1;
        for (int c = 0; c < 50 && !drained; c++) begin
            s_resp  = (tq.size() > 0);
            s_rdata = $urandom;
            cycle();
            for (int k = 0; k < N; k++) if (obs_ack[k]) m_req[k] = 1'b0;
            drained = (m_req == '0) && (tq.size() == 0);
        end
        chk("drain_done", 32'(drained), 32'd1);
        s_resp = 1'b0;

        // Spurious response with empty FIFO
        s_resp  = 1'b1;
        s_rdata = 32'hFACE;
        cycle();
        chk("spur_resp", 32'(obs_resp), 32'd0);
        s_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("spur_err_sticky", 32'(err), 32'd1);
        end

        // Reset in the middle of two outstanding reads
        set_m(0, 1'b1, 1'b0, 32'h6000, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h6100, 32'h0);
        for (int c = 0; c < 2; c++) begin
            cycle();
            for (int k = 0; k < N; k++) if (obs_ack[k]) m_req[k] = 1'b0;
        end
        chk("pre_reset_count", 32'(dut.fifo_count), 32'd2);
        m_req  = '0;
        s_ack  = 1'b0;
        arst_i = 1'b1;
        model_reset();
        #2;
        chk("mid_reset_count", 32'(dut.fifo_count), 32'd0);
        chk("mid_reset_sreq", 32'(s_req), 32'd0);
        chk("mid_reset_err", 32'(err), 32'd0);
        chk("mid_reset_ack", 32'(m_ack), 32'd0);
        #4;
        arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        s_resp  = 1'b1;
        s_rdata = 32'h77;
        cycle();
        chk("post_reset_resp", 32'(obs_resp), 32'd0);
        s_resp = 1'b0;
        cycle();
        chk("post_reset_err", 32'(err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
